// File: rtl/inst_decoder.sv
// Fetch/decode front end: fetches a 3-byte instruction from slot {Addr,k}, decodes it, and issues a one-cycle STEP.
// Optional macro IDEC_HALT_EN: byte0 == 0xFF parks the FSM in HALT (HALTED=1) until reset.
module inst_decoder (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] Addr,
  output logic       MREQ,
  output logic [9:0] MADDR,
  input  logic [7:0] MDATA,
  input  logic       MACK,
  output logic       STEP,
  output logic       MEM_INST,
  output logic       ALU_INST,
  output logic       JMP_INST,
  output logic       MS1,
  output logic       MS0,
  output logic       IRS,
  output logic       RS2,
  output logic       RS1,
  output logic       RS0,
  output logic       AR2,
  output logic       AR1,
  output logic       AR0,
  output logic       BS2,
  output logic       BS1,
  output logic       BS0,
  output logic [3:0] OP,
  output logic [7:0] IMM,
  output logic       HALTED
);

`ifdef IDEC_HALT_EN
  typedef enum logic [2:0] {S_IDLE, S_F0, S_F1, S_F2, S_EXEC, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_F0, S_F1, S_F2, S_EXEC} state_t;
`endif

  state_t     state, next_state;
  logic [7:0] byte0, byte1;
  logic [1:0] cls, ms;
  logic       irs_q;
  logic [2:0] rs, ar, bs;
  logic [3:0] op;
  logic [7:0] imm;
  logic       load_fields;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    MREQ       = 1'b0;
    MADDR      = '0;
    STEP       = 1'b0;
    case (state)
      S_IDLE: next_state = S_F0;
      S_F0: begin
        MREQ  = 1'b1;
        MADDR = {Addr, 2'd0};
        if (MACK) next_state = S_F1;
      end
      S_F1: begin
        MREQ  = 1'b1;
        MADDR = {Addr, 2'd1};
        if (MACK) next_state = S_F2;
      end
      S_F2: begin
        MREQ  = 1'b1;
        MADDR = {Addr, 2'd2};
        if (MACK) begin
`ifdef IDEC_HALT_EN
          next_state = (byte0 == 8'hFF) ? S_HALT : S_EXEC;
`else
          next_state = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        STEP       = 1'b1;
        next_state = S_F0;
      end
`ifdef IDEC_HALT_EN
      S_HALT: next_state = S_HALT;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  assign load_fields = (state == S_F2) && (next_state == S_EXEC);

  // NOTE: MREQ/STEP are decoded from this register, so the async reset drops them without a clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      byte0 <= '0;
      byte1 <= '0;
      cls   <= '0;
      ms    <= '0;
      irs_q <= 1'b0;
      rs    <= '0;
      ar    <= '0;
      bs    <= '0;
      op    <= '0;
      imm   <= '0;
    end else begin
      if (state == S_F0 && MACK) byte0 <= MDATA;
      if (state == S_F1 && MACK) byte1 <= MDATA;
      if (load_fields) begin
        cls   <= byte0[7:6];
        rs    <= byte0[5:3];
        ar    <= byte0[2:0];
        op    <= byte1[7:4];
        bs    <= byte1[3:1];
        irs_q <= byte1[0];
        imm   <= MDATA;
        case (byte0[7:6])
          2'b01:   ms <= byte1[0] ? 2'b10 : 2'b01;
          2'b11:   ms <= 2'b11;
          default: ms <= 2'b00;
        endcase
      end
    end
  end

  // Class strobes are gated by STEP so they never appear outside EXEC.
  assign ALU_INST        = STEP && (cls == 2'b00);
  assign JMP_INST        = STEP && (cls == 2'b10);
  assign MEM_INST        = STEP && (cls == 2'b11);
  assign {MS1, MS0}      = ms;
  assign IRS             = irs_q;
  assign {RS2, RS1, RS0} = rs;
  assign {AR2, AR1, AR0} = ar;
  assign {BS2, BS1, BS0} = bs;
  assign OP              = op;
  assign IMM             = imm;

`ifdef IDEC_HALT_EN
  assign HALTED = (state == S_HALT);
`else
  assign HALTED = 1'b0;
`endif

endmodule

// File: doc/inst_decoder.md
# inst_decoder

- Fetch/decode front end that drives the core.
- Each instruction:
  - Takes the 8-bit PC (`Addr`) from the core.
  - Fetches a 3-byte instruction from byte-wide program memory over a request/acknowledge handshake.
  - Decodes it into the core's control bundle (MEM/ALU/JMP strobes, MS, IRS, RS/AR/BS selects, OP, IMM).
  - Issues a one-cycle `STEP` strobe that advances the core by one instruction.
- Sits between program memory and the core; it is the producer of everything the core consumes except `CLK`.

## Interface
Parameters:
- none (instruction width is fixed at 24 bits; slot stride is fixed at 4 bytes)

Ports:
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `Addr` in 8: current PC from the core.
- `MREQ` out 1: program-memory read request.
- `MADDR` out 10: byte address, `{Addr, k[1:0]}`, k = 0..2.
- `MDATA` in 8: read data; valid when `MACK`=1.
- `MACK` in 1: memory acknowledge; ignored while `MREQ`=0.
- `STEP` out 1: one-cycle strobe; the decoded instruction executes in this cycle.
- `MEM_INST`, `ALU_INST`, `JMP_INST` out 1 each: class strobes; may be high only while `STEP`=1.
- `MS1`, `MS0`, `IRS`, `RS2..RS0`, `AR2..AR0`, `BS2..BS0` out 1 each: decoded selects.
- `OP` out 4: ALU opcode / branch condition.
- `IMM` out 8: immediate / jump target.
- `HALTED` out 1: only when `IDEC_HALT_EN` is defined; otherwise tied 0.

## Operation
Encoding:
- byte0 = `{class[1:0], RS[2:0], AR[2:0]}`
- byte1 = `{OP[3:0], BS[2:0], IRS}`
- byte2 = `IMM`

Class decode:

| class | Meaning | Strobe | MS |
|---|---|---|---|
| 00 | ALU | `ALU_INST` | 00 |
| 01 | MOV | none | 01 if IRS=0, 10 if IRS=1 |
| 10 | JMP | `JMP_INST` | 00 |
| 11 | MEM | `MEM_INST` | 11 |

FSM states: IDLE, F0, F1, F2, EXEC (plus HALT when `IDEC_HALT_EN` is defined).

State transitions:
- IDLE → F0 unconditionally.
- Fk: `MREQ`=1, `MADDR`={Addr,k}. Stay in Fk until `MACK`=1. On the `MACK` edge, latch `MDATA` into byte k and advance: F0→F1→F2→EXEC.
- EXEC: `STEP`=1, class strobe per decode; then → F0.

Output behaviour:
- `MREQ`/`MADDR` are Moore outputs of state.
- `Addr` is sampled combinationally in F0..F2. The core updates `Addr` only on `STEP`, so `Addr` is stable for the whole fetch.
- Decoded fields (MS, IRS, RS, AR, BS, OP, IMM) are registered on the F2→EXEC edge and held until the next F2→EXEC edge.
- Class strobes are 0 outside EXEC.

## Timing
Reset:
- All outputs 0: `MREQ`=0, `MADDR`=0, `STEP`=0, strobes 0, fields 0, `HALTED`=0. State = IDLE.
- Reset asserted mid-fetch or in EXEC drops `MREQ`/`STEP` immediately, without waiting for a clock edge. Partial bytes are discarded.

Latency and throughput:
- With zero-wait memory (`MACK`=1 in the same cycle as `MREQ`), first `MREQ` is the 2nd cycle after `RST` falls and first `STEP` the 5th.
- Steady-state throughput is 1 instruction per 4 cycles.
- Each wait cycle (`MREQ`=1, `MACK`=0) adds one cycle. `MREQ` and `MADDR` hold stable through waits.

Boundary conditions:
- `MACK` while `MREQ`=0 has no effect.
- PC 0xFF maps to MADDR 0x3FC..0x3FE. PC wrap is the core's concern; no special case here.
- Byte 3 of each slot is never read.

## Configuration
- `IDEC_HALT_EN` defined: byte0 = 0xFF decodes as HALT. On the F2 edge the FSM enters HALT, not EXEC:
  - no `STEP`, `MREQ`=0, `HALTED`=1;
  - remains there until `RST`;
  - decoded field registers are not updated.
- `IDEC_HALT_EN` undefined: 0xFF is an ordinary MEM instruction (RS=7, AR=7). There is no HALT state and `HALTED` is constant 0.

## Test plan
- **Reset/startup:** Hold `RST` 3 cycles, release, memory acks immediately. Required:
  - all outputs are 0 during reset;
  - `MREQ` rises in the 2nd cycle;
  - `MADDR` = 0x000, 0x001, 0x002;
  - `STEP` is seen in the 5th cycle.
- **ALU decode:** Addr=0x05, bytes 0x0A,0x35,0x00. Required:
  - `MADDR` = 0x014..0x016;
  - at `STEP`: `ALU_INST`=1, MS=00, RS=1, AR=2, OP=3, BS=2, IRS=1, IMM=0x00.
- **MOV-immediate and JMP:**
  - bytes 0x60,0x01,0x7F → `STEP` with no strobe, MS=10, RS=4, IMM=0x7F;
  - next bytes 0x80,0x70,0x20 → `JMP_INST`=1, OP=7, IMM=0x20.
- **Wait states:** `MACK` delayed 3 cycles on byte1. Required:
  - `MREQ`=1 and `MADDR` stable throughout the wait;
  - `STEP` is 3 cycles later than in the zero-wait case;
  - decoded fields are unchanged until `STEP`.
- **Async reset mid-fetch:** Assert `RST` between clock edges while in F1. Required:
  - `MREQ` falls before the next edge;
  - after release, fetch restarts at byte0 with no `STEP` from the old instruction.
- **Halt:** Bytes 0xFF,0x00,0x00. Required:
  - with `IDEC_HALT_EN`: `HALTED`=1, no `STEP`, `MREQ`=0 for 20 cycles;
  - without `IDEC_HALT_EN`: `MEM_INST`=1, MS=11, RS=7, AR=7, then fetch continues.
